uart_receiver: RTL and testbench



---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_baud_gen.sv | 24 ++
 rtl/uart_receiver.sv | 150 +++++++++++++++
 tb/tb_uart_receiver.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and constants
package uart_pkg;

    typedef enum logic [2:0] {
        UART_RX_IDLE,
        UART_RX_START,
        UART_RX_DATA,
        UART_RX_STOP,
        UART_RX_WAIT_IDLE
    } uart_rx_state_t;

    localparam int UART_OVERSAMPLE = 16;
    localparam int UART_DATA_BITS  = 8;

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - oversampling tick prescaler, tick every div+1 cycles
module uart_baud_gen (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic [7:0] div,
    output logic       tick
);

    logic [7:0] r_cnt;

    assign tick = (r_cnt == div);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= 8'd0;
        end else if (clear || tick) begin
            r_cnt <= 8'd0;
        end else begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - x16 oversampled 8N1 receive core
module uart_receiver
    import uart_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int OVERSAMPLE  = UART_OVERSAMPLE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] clk_divider,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_err,
    output logic       rx_busy
);

    localparam logic [3:0] SMP_LAST = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] SMP_MID  = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [2:0] BIT_LAST = 3'(UART_DATA_BITS - 1);

    uart_rx_state_t r_state;
    uart_rx_state_t w_state_next;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_rxd_prev;
    logic [3:0]             r_sample_cnt;
    logic [2:0]             r_bit_cnt;
    logic [7:0]             r_shift;
    logic [7:0]             r_div_l;
    logic [7:0]             r_rx_data;
    logic                   r_rx_valid;
    logic                   r_rx_err;

    logic w_rxd_s;
    logic w_start;
    logic w_tick;
    logic w_baud_clear;
    logic w_valid_next;
    logic w_err_next;

    assign w_rxd_s      = r_sync[SYNC_STAGES-1];
    assign w_start      = (r_state == UART_RX_IDLE) && en && r_rxd_prev && !w_rxd_s;
    // Prescaler is held at zero outside a frame so START always begins on a fresh count
    assign w_baud_clear = (r_state == UART_RX_IDLE) || (r_state == UART_RX_WAIT_IDLE) || !en;

    uart_baud_gen u_baud_gen (
        .clk   (clk),
        .rst   (rst),
        .clear (w_baud_clear),
        .div   (r_div_l),
        .tick  (w_tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= UART_RX_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_valid_next = 1'b0;
        w_err_next   = 1'b0;
        if (!en) begin
            w_state_next = UART_RX_IDLE;
        end else begin
            case (r_state)
                UART_RX_IDLE: begin
                    if (w_start) w_state_next = UART_RX_START;
                end
                UART_RX_START: begin
                    if (w_tick && r_sample_cnt == SMP_MID)
                        w_state_next = w_rxd_s ? UART_RX_IDLE : UART_RX_DATA;
                end
                UART_RX_DATA: begin
                    if (w_tick && r_sample_cnt == SMP_LAST && r_bit_cnt == BIT_LAST)
                        w_state_next = UART_RX_STOP;
                end
                UART_RX_STOP: begin
                    if (w_tick && r_sample_cnt == SMP_LAST) begin
                        if (w_rxd_s) begin
                            w_valid_next = 1'b1;
                            w_state_next = UART_RX_IDLE;
                        end else begin
                            w_err_next   = 1'b1;
                            w_state_next = UART_RX_WAIT_IDLE;
                        end
                    end
                end
                UART_RX_WAIT_IDLE: begin
                    if (w_rxd_s) w_state_next = UART_RX_IDLE;
                end
                default: w_state_next = UART_RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync       <= '1;
            r_rxd_prev   <= 1'b1;
            r_sample_cnt <= 4'd0;
            r_bit_cnt    <= 3'd0;
            r_shift      <= 8'h00;
            r_div_l      <= 8'h00;
            r_rx_data    <= 8'h00;
            r_rx_valid   <= 1'b0;
            r_rx_err     <= 1'b0;
        end else begin
            r_sync     <= {r_sync[SYNC_STAGES-2:0], rxd};
            r_rxd_prev <= w_rxd_s;
            r_rx_valid <= w_valid_next;
            r_rx_err   <= w_err_next;
            if (w_valid_next) r_rx_data <= r_shift;

            if (!en || w_start) begin
                r_sample_cnt <= 4'd0;
                r_bit_cnt    <= 3'd0;
                if (w_start) r_div_l <= clk_divider;
            end else if (w_tick) begin
                case (r_state)
                    UART_RX_START: begin
                        r_sample_cnt <= (r_sample_cnt == SMP_MID) ? 4'd0 : r_sample_cnt + 4'd1;
                        r_bit_cnt    <= 3'd0;
                    end
                    UART_RX_DATA: begin
                        r_sample_cnt <= r_sample_cnt + 4'd1;
                        // LSB arrives first, so shifting in at the top leaves it in bit 0
                        if (r_sample_cnt == SMP_LAST) begin
                            r_shift   <= {w_rxd_s, r_shift[7:1]};
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                        end
                    end
                    UART_RX_STOP: r_sample_cnt <= r_sample_cnt + 4'd1;
                    default:      r_sample_cnt <= 4'd0;
                endcase
            end
        end
    end

    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;
    assign rx_err   = r_rx_err;
    assign rx_busy  = (r_state != UART_RX_IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - self-checking bench for uart_receiver
module tb_uart_receiver;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] clk_divider;
    logic       rxd;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_err;
    logic       rx_busy;

    typedef struct {
        int         cyc;
        bit         is_err;
        logic [7:0] data;
    } evt_t;

    evt_t       q[$];
    int         checks = 0;
    int         failures = 0;
    int         cycle = 0;
    int         last_valid_cyc = -1;
    int         last_start = 0;
    logic [7:0] model_data = 8'h00;

    uart_receiver #(.SYNC_STAGES(2), .OVERSAMPLE(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .clk_divider (clk_divider),
        .rxd         (rxd),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_err      (rx_err),
        .rx_busy     (rx_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: actual=%0h required=%0h", name, cycle, act, exp);
        end
    endtask

    // Frame-level model: a frame ends 3 sync/detect cycles plus 152 ticks after its start edge
    always @(negedge clk) begin
        bit exp_v;
        bit exp_e;
        exp_v = 1'b0;
        exp_e = 1'b0;
        if (rst) model_data = 8'h00;
        if (q.size() > 0 && q[0].cyc == cycle) begin
            if (q[0].is_err) exp_e = 1'b1;
            else begin
                exp_v = 1'b1;
                model_data = q[0].data;
            end
            void'(q.pop_front());
        end
        chk("rx_valid", {31'd0, rx_valid}, {31'd0, exp_v});
        chk("rx_err", {31'd0, rx_err}, {31'd0, exp_e});
        chk("rx_data", {24'd0, rx_data}, {24'd0, model_data});
        if (rx_valid) last_valid_cyc = cycle;
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        rxd = 1'b1;
        step(n);
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop_v, input int period,
                              input int exp_div, input bit expect_evt, input int abort_bit,
                              input int mid_div);
        logic v;
        last_start = cycle;
        if (expect_evt)
            q.push_back('{cyc: cycle + 3 + 152 * (exp_div + 1), is_err: !stop_v, data: data});
        for (int b = 0; b < 10; b++) begin
            v = (b == 0) ? 1'b0 : (b == 9) ? stop_v : data[b-1];
            for (int c = 0; c < period; c++) begin
                rxd = v;
                if (b == abort_bit && c == 0) en = 1'b0;
                if (b == abort_bit && c == 1) chk("abort_busy", {31'd0, rx_busy}, 32'd0);
                if (b == 4 && c == 0 && mid_div >= 0) clk_divider = 8'(mid_div);
                @(posedge clk);
                #1;
            end
        end
    endtask

    initial begin
        int k;
        int s2;
        rst = 1'b1;
        en = 1'b0;
        clk_divider = 8'd0;
        rxd = 1'b1;
        step(3);
        chk("reset_data", {24'd0, rx_data}, 32'h00);
        chk("reset_valid", {31'd0, rx_valid}, 32'd0);
        chk("reset_err", {31'd0, rx_err}, 32'd0);
        chk("reset_busy", {31'd0, rx_busy}, 32'd0);
        rst = 1'b0;
        en = 1'b1;
        idle(20);

        // nominal byte at 16 clk/bit
        send_frame(8'hA5, 1'b1, 16, 0, 1'b1, -1, -1);
        idle(20);
        chk("nom_latency", last_valid_cyc - last_start, 32'd155);
        chk("nom_data", {24'd0, rx_data}, 32'hA5);

        // 4-cycle glitch
        rxd = 1'b0;
        step(4);
        chk("glitch_busy_set", {31'd0, rx_busy}, 32'd1);
        rxd = 1'b1;
        k = 0;
        while (rx_busy && k < 10) begin
            step(1);
            k++;
        end
        chk("glitch_busy_clear", {31'd0, rx_busy}, 32'd0);
        idle(20);

        // framing error followed by a 40-bit break
        send_frame(8'h3C, 1'b0, 16, 0, 1'b1, -1, -1);
        rxd = 1'b0;
        step(40 * 16);
        chk("break_busy", {31'd0, rx_busy}, 32'd1);
        rxd = 1'b1;
        step(4);
        chk("break_release_busy", {31'd0, rx_busy}, 32'd0);
        chk("ferr_data_kept", {24'd0, rx_data}, 32'hA5);
        idle(20);

        // back-to-back at 64 clk/bit, divider disturbed during the second frame
        clk_divider = 8'd3;
        send_frame(8'h00, 1'b1, 64, 3, 1'b1, -1, -1);
        send_frame(8'hFF, 1'b1, 64, 3, 1'b1, -1, 7);
        s2 = last_start;
        clk_divider = 8'd3;
        idle(100);
        chk("b2b_latency", last_valid_cyc - s2, 32'd611);
        chk("b2b_data", {24'd0, rx_data}, 32'hFF);

        // enable abort at data bit 4, then a clean frame
        clk_divider = 8'd0;
        send_frame(8'h5A, 1'b1, 16, 0, 1'b0, 5, -1);
        idle(20);
        chk("abort_data_kept", {24'd0, rx_data}, 32'hFF);
        en = 1'b1;
        idle(4);
        send_frame(8'h81, 1'b1, 16, 0, 1'b1, -1, -1);
        idle(20);
        chk("reenable_data", {24'd0, rx_data}, 32'h81);

        // asynchronous reset mid-frame
        for (int b = 0; b < 5; b++) begin
            rxd = (b == 0) ? 1'b0 : k[0];
            step(16);
        end
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("rst_abort_data", {24'd0, rx_data}, 32'h00);
        chk("rst_abort_busy", {31'd0, rx_busy}, 32'd0);
        chk("rst_abort_valid", {31'd0, rx_valid}, 32'd0);
        rxd = 1'b1;
        step(20);
        rst = 1'b0;
        idle(10);

        // baud tolerance, transmitter at 61 and 67 clk/bit
        clk_divider = 8'd3;
        send_frame(8'h55, 1'b1, 61, 3, 1'b1, -1, -1);
        idle(128);
        send_frame(8'hAA, 1'b1, 67, 3, 1'b1, -1, -1);
        idle(128);
        send_frame(8'hAA, 1'b1, 61, 3, 1'b1, -1, -1);
        idle(128);
        send_frame(8'h55, 1'b1, 67, 3, 1'b1, -1, -1);
        idle(128);
        chk("tol_data", {24'd0, rx_data}, 32'h55);

        chk("events_pending", q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
